// File: rtl/bt_apb_timer.sv
// APB completer wrapping a 32-bit down-counting timer with prescaler,
// auto-reload / one-shot modes and a level interrupt.
module bt_apb_timer #(
  parameter int unsigned PRESC_W      = 8,
  parameter logic [31:0] RESET_RELOAD = 32'h0000_0000
) (
  input  logic        pclkg,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:2] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        timer_int
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_VALUE   = 2'd1,
    REG_RELOAD  = 2'd2,
    REG_INTSTAT = 2'd3
  } reg_e;

  logic               en;
  logic               irqen;
  logic               oneshot;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic [31:0]        value;
  logic [31:0]        reload;
  logic               intstatus;

  logic        mapped;
  reg_e        reg_sel;
  logic        wr_en;
  logic        wr_ctrl;
  logic        wr_value;
  logic        wr_reload;
  logic        wr_intstat;
  logic        tick;
  logic        expire;
  logic [31:0] ctrl_rd;

  // Only the first four words of the 4 KB slot are decoded.
  assign mapped  = (paddr[11:4] == '0);
  assign reg_sel = reg_e'(paddr[3:2]);

  assign wr_en      = psel & penable & pwrite & mapped;
  assign wr_ctrl    = wr_en & (reg_sel == REG_CTRL);
  assign wr_value   = wr_en & (reg_sel == REG_VALUE);
  assign wr_reload  = wr_en & (reg_sel == REG_RELOAD);
  assign wr_intstat = wr_en & (reg_sel == REG_INTSTAT);

  assign tick   = en & (presc_cnt == presc);
  assign expire = tick & (value == '0);

  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      presc_cnt <= '0;
    end else if (wr_ctrl || !en || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  // A CTRL write takes priority over the one-shot self-disable.
  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      en      <= 1'b0;
      irqen   <= 1'b0;
      oneshot <= 1'b0;
      presc   <= '0;
    end else if (wr_ctrl) begin
      en      <= pwdata[0];
      irqen   <= pwdata[1];
      oneshot <= pwdata[2];
      presc   <= pwdata[8 +: PRESC_W];
    end else if (expire && oneshot) begin
      en      <= 1'b0;
    end
  end

  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      value <= RESET_RELOAD;
    end else if (wr_value) begin
      value <= pwdata;
    end else if (tick) begin
      if (value != '0) begin
        value <= value - 32'd1;
      end else if (!oneshot) begin
        value <= reload;
      end
    end
  end

  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      reload <= RESET_RELOAD;
    end else if (wr_reload) begin
      reload <= pwdata;
    end
  end

  // Setting on expiry outranks a software clear in the same cycle.
  always_ff @(posedge pclkg or negedge presetn) begin
    if (!presetn) begin
      intstatus <= 1'b0;
    end else if (expire) begin
      intstatus <= 1'b1;
    end else if (wr_intstat && pwdata[0]) begin
      intstatus <= 1'b0;
    end
  end

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[0]           = en;
    ctrl_rd[1]           = irqen;
    ctrl_rd[2]           = oneshot;
    ctrl_rd[8 +: PRESC_W] = presc;
  end

  always_comb begin
    prdata = '0;
    if (psel && !pwrite && mapped) begin
      case (reg_sel)
        REG_CTRL:    prdata = ctrl_rd;
        REG_VALUE:   prdata = value;
        REG_RELOAD:  prdata = reload;
        REG_INTSTAT: prdata = {31'b0, intstatus};
        default:     prdata = '0;
      endcase
    end
  end

  assign pready    = 1'b1;
  assign pslverr   = psel & penable & ~mapped;
  assign timer_int = intstatus & irqen;

endmodule

// File: tb/tb_bt_apb_timer.sv
// Scoreboard bench for bt_apb_timer: stimulus pushes expected responses,
// a negedge monitor pops and compares on every access phase or probe.
module tb_bt_apb_timer;

  logic        pclkg = 1'b0;
  logic        presetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:2] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        timer_int;

  bt_apb_timer #(.PRESC_W(8), .RESET_RELOAD(32'h0000_0000)) dut (
    .pclkg    (pclkg),
    .presetn  (presetn),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .timer_int(timer_int)
  );

  always #5 pclkg = ~pclkg;

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_VALUE  = 12'h004;
  localparam logic [11:0] A_RELOAD = 12'h008;
  localparam logic [11:0] A_INT    = 12'h00C;
  localparam logic [11:0] A_BAD0   = 12'h010;
  localparam logic [11:0] A_BAD1   = 12'hFFC;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    logic        intr;
  } exp_t;

  exp_t apb_q[$];
  exp_t prb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic probe = 1'b0;

  always @(negedge pclkg) begin
    exp_t e;
    if (presetn === 1'b1 && psel && penable) begin
      n_cmp++;
      if (apb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_access: no expectation queued at t=%0t", $time);
      end else begin
        e = apb_q.pop_front();
        if (prdata !== e.data || pslverr !== e.err || timer_int !== e.intr || pready !== 1'b1) begin
          n_bad++;
          $display("FAIL %s: got prdata=%h pslverr=%b timer_int=%b pready=%b, want prdata=%h pslverr=%b timer_int=%b pready=1",
                   e.name, prdata, pslverr, timer_int, pready, e.data, e.err, e.intr);
        end
      end
    end
    if (probe) begin
      n_cmp++;
      if (prb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_probe: no expectation queued at t=%0t", $time);
      end else begin
        e = prb_q.pop_front();
        if (prdata !== 32'h0 || pslverr !== 1'b0 || timer_int !== e.intr || pready !== 1'b1) begin
          n_bad++;
          $display("FAIL %s: got prdata=%h pslverr=%b timer_int=%b pready=%b, want prdata=0 pslverr=0 timer_int=%b pready=1",
                   e.name, prdata, pslverr, timer_int, pready, e.intr);
        end
      end
    end
  end

  // All tasks start and end 1 ns after a rising edge.
  task automatic apb_wr(input logic [11:0] addr, input logic [31:0] data,
                        input logic err, input logic intr, input string name);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr[11:2]; pwdata = data;
    apb_q.push_back('{name, 32'h0, err, intr});
    @(posedge pclkg); #1;
    penable = 1'b1;
    @(posedge pclkg); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] addr, input logic [31:0] exp_data,
                        input logic err, input logic intr, input string name);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr[11:2];
    apb_q.push_back('{name, exp_data, err, intr});
    @(posedge pclkg); #1;
    penable = 1'b1;
    @(posedge pclkg); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_probe(input logic intr, input string name);
    prb_q.push_back('{name, 32'h0, 1'b0, intr});
    probe = 1'b1;
    @(posedge pclkg); #1;
    probe = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge pclkg); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (2) @(posedge pclkg);
    #1;
    do_probe(1'b0, "por_outputs");
    #3 presetn = 1'b1;
    @(posedge pclkg); #1;

    // Reset while counting and mid-write
    apb_wr(A_VALUE,  32'd1, 1'b0, 1'b0, "rst_wr_value");
    apb_wr(A_RELOAD, 32'd1, 1'b0, 1'b0, "rst_wr_reload");
    apb_wr(A_CTRL,   32'h3, 1'b0, 1'b0, "rst_wr_ctrl");
    idle(3);
    do_probe(1'b1, "rst_pre_int");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_VALUE[11:2]; pwdata = 32'h55;
    @(posedge pclkg); #1;
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge pclkg); #1;
    do_probe(1'b0, "rst_in_reset");
    #2 presetn = 1'b1;
    @(posedge pclkg); #1;
    do_probe(1'b0, "rst_after");
    apb_rd(A_CTRL,   32'h0, 1'b0, 1'b0, "rst_rd_ctrl");
    apb_rd(A_VALUE,  32'h0, 1'b0, 1'b0, "rst_rd_value");
    apb_rd(A_RELOAD, 32'h0, 1'b0, 1'b0, "rst_rd_reload");
    apb_rd(A_INT,    32'h0, 1'b0, 1'b0, "rst_rd_int");

    // Register read/write
    apb_wr(A_RELOAD, 32'hDEAD_BEEF, 1'b0, 1'b0, "rw_wr_reload");
    apb_wr(A_CTRL,   32'hFFFF_FFFF, 1'b0, 1'b0, "rw_wr_ctrl");
    apb_rd(A_RELOAD, 32'hDEAD_BEEF, 1'b0, 1'b0, "rw_rd_reload");
    apb_rd(A_CTRL,   32'h0000_FF07, 1'b0, 1'b0, "rw_rd_ctrl");
    apb_wr(A_CTRL,   32'h0, 1'b0, 1'b0, "rw_wr_ctrl_off");

    // Auto-reload, PRESC=0, IRQEN
    apb_wr(A_VALUE,  32'd3, 1'b0, 1'b0, "ar_wr_value");
    apb_wr(A_RELOAD, 32'd3, 1'b0, 1'b0, "ar_wr_reload");
    apb_wr(A_CTRL,   32'h3, 1'b0, 1'b0, "ar_wr_ctrl");
    apb_rd(A_VALUE,  32'd2, 1'b0, 1'b0, "ar_value_c1");
    do_probe(1'b0, "ar_int_c2");
    do_probe(1'b0, "ar_int_c3");
    do_probe(1'b1, "ar_int_c4");
    apb_rd(A_VALUE,  32'd1, 1'b0, 1'b1, "ar_value_c6");
    do_probe(1'b1, "ar_int_c7");
    apb_wr(A_INT,    32'h1, 1'b0, 1'b1, "ar_clear");
    do_probe(1'b0, "ar_int_c10");
    do_probe(1'b0, "ar_int_c11");
    do_probe(1'b1, "ar_int_c12");
    apb_rd(A_INT,    32'h1, 1'b0, 1'b1, "ar_rd_int");
    apb_wr(A_CTRL,   32'h0, 1'b0, 1'b1, "ar_stop");
    apb_wr(A_INT,    32'h1, 1'b0, 1'b0, "ar_clear2");

    // Prescaler + one-shot, IRQEN=0
    apb_wr(A_VALUE,  32'd2, 1'b0, 1'b0, "os_wr_value");
    apb_wr(A_CTRL,   32'h0405, 1'b0, 1'b0, "os_wr_ctrl");
    apb_rd(A_VALUE,  32'd2, 1'b0, 1'b0, "os_value_c1");
    idle(2);
    apb_rd(A_VALUE,  32'd1, 1'b0, 1'b0, "os_value_c5");
    idle(2);
    apb_rd(A_VALUE,  32'd1, 1'b0, 1'b0, "os_value_c9");
    apb_rd(A_INT,    32'h0, 1'b0, 1'b0, "os_int_c11");
    apb_rd(A_INT,    32'h0, 1'b0, 1'b0, "os_int_c13");
    apb_rd(A_INT,    32'h1, 1'b0, 1'b0, "os_int_c15");
    apb_rd(A_CTRL,   32'h0404, 1'b0, 1'b0, "os_ctrl_after");
    apb_rd(A_VALUE,  32'd0, 1'b0, 1'b0, "os_value_after");
    idle(10);
    apb_rd(A_VALUE,  32'd0, 1'b0, 1'b0, "os_value_hold");
    apb_wr(A_INT,    32'h1, 1'b0, 1'b0, "os_clear");

    // VALUE write on a tick cycle (PRESC=3: ticks 4, 8, ... after CTRL)
    apb_wr(A_VALUE,  32'd50, 1'b0, 1'b0, "cv_wr_value50");
    apb_wr(A_CTRL,   32'h0301, 1'b0, 1'b0, "cv_wr_ctrl");
    idle(2);
    apb_wr(A_VALUE,  32'd100, 1'b0, 1'b0, "cv_wr_value100");
    apb_rd(A_VALUE,  32'd100, 1'b0, 1'b0, "cv_value_c5");
    apb_rd(A_VALUE,  32'd100, 1'b0, 1'b0, "cv_value_c7");
    apb_rd(A_VALUE,  32'd99, 1'b0, 1'b0, "cv_value_c9");
    apb_wr(A_CTRL,   32'h0, 1'b0, 1'b0, "cv_stop");

    // INTSTATUS clear on the expiry cycle
    apb_wr(A_VALUE,  32'd1, 1'b0, 1'b0, "ci_wr_value");
    apb_wr(A_RELOAD, 32'd5, 1'b0, 1'b0, "ci_wr_reload");
    apb_wr(A_CTRL,   32'h1, 1'b0, 1'b0, "ci_wr_ctrl");
    apb_wr(A_INT,    32'h1, 1'b0, 1'b0, "ci_clear_on_set");
    apb_rd(A_INT,    32'h1, 1'b0, 1'b0, "ci_int_kept");
    apb_rd(A_VALUE,  32'd2, 1'b0, 1'b0, "ci_value_reloaded");
    apb_wr(A_CTRL,   32'h0, 1'b0, 1'b0, "ci_stop");
    apb_wr(A_INT,    32'h1, 1'b0, 1'b0, "ci_clear");
    apb_rd(A_INT,    32'h0, 1'b0, 1'b0, "ci_int_cleared");

    // Unmapped accesses
    apb_wr(A_VALUE,  32'h1234, 1'b0, 1'b0, "er_wr_value");
    apb_wr(A_RELOAD, 32'h55, 1'b0, 1'b0, "er_wr_reload");
    apb_wr(A_CTRL,   32'h0302, 1'b0, 1'b0, "er_wr_ctrl");
    apb_rd(A_BAD0,   32'h0, 1'b1, 1'b0, "er_rd_010");
    apb_wr(A_BAD0,   32'hFFFF_FFFF, 1'b1, 1'b0, "er_wr_010");
    apb_rd(A_BAD1,   32'h0, 1'b1, 1'b0, "er_rd_ffc");
    apb_wr(A_BAD1,   32'hFFFF_FFFF, 1'b1, 1'b0, "er_wr_ffc");
    apb_rd(A_CTRL,   32'h0302, 1'b0, 1'b0, "er_ctrl_kept");
    apb_rd(A_VALUE,  32'h1234, 1'b0, 1'b0, "er_value_kept");
    apb_rd(A_RELOAD, 32'h55, 1'b0, 1'b0, "er_reload_kept");
    apb_rd(A_INT,    32'h0, 1'b0, 1'b0, "er_int_kept");

    idle(3);
    if (apb_q.size() != 0 || prb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d apb and %0d probe entries left, want 0 and 0",
               apb_q.size(), prb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
